// File: rtl/keystroke_pkg.sv
// keystroke_pkg: shared scan-code constants and FSM state types for the keystroke sequencer.
package keystroke_pkg;
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_NULL  = 8'h00;
  typedef enum logic [1:0] {D_IDLE, D_BRK, D_EXT, D_EXTBRK} dec_state_e;
  typedef enum logic [1:0] {S_IDLE, S_ENC, S_ROT, S_SETTLE} sch_state_e;
endpackage

// File: rtl/keystroke_fifo.sv
// keystroke_fifo: power-of-two circular buffer; a push on a full buffer lands only when a pop frees the slot.
module keystroke_fifo
  import keystroke_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      level_q, level_d;
  logic             do_push, do_pop;
  assign full_o  = level_q == (AW+1)'(DEPTH);
  assign empty_o = level_q == '0;
  assign level_o = level_q;
  assign rdata_o = mem_q[rd_q];
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign level_d = (do_push && !do_pop) ? level_q + 1'b1 :
                   (!do_push && do_pop) ? level_q - 1'b1 : level_q;
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop) rd_q <= rd_q + 1'b1;
      level_q <= level_d;
    end
  end
endmodule

// File: rtl/keystroke_sequencer.sv
// keystroke_sequencer: turns the raw PS/2 byte stream into make events, queues them, and walks
// each key through the encryptor (present, await result, rotor step, settle).
module keystroke_sequencer
  import keystroke_pkg::*;
#(
  parameter int FIFO_DEPTH    = 4,
  parameter int SETTLE_CYCLES = 5000,
  parameter int ENC_TIMEOUT   = 255
) (
  input  logic                          CLOCK_50,
  input  logic                          reset_n,
  input  logic [7:0]                    rx_data,
  input  logic                          rx_en,
  input  logic                          enc_valid,
  input  logic [7:0]                    enc_data,
  output logic [7:0]                    key_code,
  output logic                          rotate,
  output logic [7:0]                    cipher_out,
  output logic                          cipher_valid,
  output logic                          timeout_err,
  output logic [7:0]                    drop_count,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          busy
);
  dec_state_e dec_q;
  sch_state_e sch_q;
  logic [7:0]  held_q, key_q, cipher_q, drop_q;
  logic [31:0] timer_q;
  logic        rot_q, cv_q, terr_q;
  logic        push, pop, full, empty, drop;
  logic [7:0]  head;
  assign push = rx_en && dec_q == D_IDLE && rx_data != SC_EXT && rx_data != SC_BREAK &&
                rx_data != SC_NULL && rx_data != held_q;
  assign pop  = sch_q == S_IDLE && !empty;
  assign drop = push && full && !pop;
  keystroke_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk     (CLOCK_50),
    .rst_n   (reset_n),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (rx_data),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .level_o (fifo_level)
  );
  // held_q remembers the key currently down so typematic repeats are swallowed
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      dec_q  <= D_IDLE;
      held_q <= '0;
    end else if (rx_en) begin
      case (dec_q)
        D_IDLE: begin
          dec_q <= rx_data == SC_EXT ? D_EXT : rx_data == SC_BREAK ? D_BRK : D_IDLE;
          if (push) held_q <= rx_data;
        end
        D_BRK: begin
          dec_q <= D_IDLE;
          if (rx_data == held_q) held_q <= '0;
        end
        D_EXT:    dec_q <= rx_data == SC_BREAK ? D_EXTBRK : D_IDLE;
        default:  dec_q <= D_IDLE;
      endcase
    end
  end
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) drop_q <= '0;
    else if (drop && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
  end
  // rotate is the registered image of S_ROT, so it lands one cycle after cipher_valid
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      sch_q    <= S_IDLE;
      timer_q  <= '0;
      key_q    <= '0;
      cipher_q <= '0;
      cv_q     <= 1'b0;
      rot_q    <= 1'b0;
      terr_q   <= 1'b0;
    end else begin
      cv_q  <= 1'b0;
      rot_q <= 1'b0;
      case (sch_q)
        S_IDLE: if (!empty) begin
          key_q   <= head;
          timer_q <= '0;
          sch_q   <= S_ENC;
        end
        S_ENC: begin
          if (enc_valid) begin
            cipher_q <= enc_data;
            cv_q     <= 1'b1;
            sch_q    <= S_ROT;
          end else if (timer_q == 32'(ENC_TIMEOUT - 1)) begin
            terr_q <= 1'b1;
            sch_q  <= S_ROT;
          end else begin
            timer_q <= timer_q + 32'd1;
          end
        end
        S_ROT: begin
          rot_q   <= 1'b1;
          timer_q <= '0;
          sch_q   <= S_SETTLE;
        end
        default: begin
          if (timer_q == 32'(SETTLE_CYCLES - 1)) sch_q <= S_IDLE;
          else timer_q <= timer_q + 32'd1;
        end
      endcase
    end
  end
  assign key_code     = key_q;
  assign rotate       = rot_q;
  assign cipher_out   = cipher_q;
  assign cipher_valid = cv_q;
  assign timeout_err  = terr_q;
  assign drop_count   = drop_q;
  assign busy         = sch_q != S_IDLE;
endmodule
